// File: rtl/fc_layer_sequencer_if.sv
// Handshake bundle between the FC layer sequencer, the FC buffer switch and the FC MAC engine.
// The sequencer takes the master side. The buffer switch and the engine take the slave side.
interface fc_layer_sequencer_if #(
  parameter int CNT_WIDTH = 16
) ();
  logic                 enable;
  logic                 FC_data_valid;
  logic                 FC_buffer_switch;
  logic [1:0]           layer_idx;
  logic [CNT_WIDTH-1:0] fin_words;
  logic [CNT_WIDTH-1:0] neu_idx;
  logic                 neu_start;
  logic                 neu_done;
  logic                 layer_done;
  logic [CNT_WIDTH-1:0] frame_cnt;
  logic                 busy;
  logic                 err;

  modport master (
    input  enable, FC_data_valid, neu_done,
    output FC_buffer_switch, layer_idx, fin_words, neu_idx, neu_start,
           layer_done, frame_cnt, busy, err
  );

  modport slave (
    output enable, FC_data_valid, neu_done,
    input  FC_buffer_switch, layer_idx, fin_words, neu_idx, neu_start,
           layer_done, frame_cnt, busy, err
  );
endinterface

// File: rtl/fc_layer_sequencer.sv
// Walks the FC MAC engine through every layer of one buffered frame, one neuron at a time.
// When the frame is done, it hands the ping-pong buffer back to the buffer switch.
module fc_layer_sequencer #(
  parameter int LAYERS    = 3,
  parameter int AF        = 3,
  parameter int FIN1      = 8379,
  parameter int FIN2      = 1366,
  parameter int FIN3      = 1366,
  parameter int FIN4      = 1,
  parameter int FOUT1     = 4096,
  parameter int FOUT2     = 4096,
  parameter int FOUT3     = 1000,
  parameter int FOUT4     = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fc_layer_sequencer_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_VALID,
    LAYER_CFG,
    NEU_ISSUE,
    NEU_WAIT,
    LAYER_END,
    SWITCH,
    DRAIN
  } state_t;

  // Word counts per layer, rounded up because a partial word still costs a read.
  localparam int FW1 = (FIN1 + AF - 1) / AF;
  localparam int FW2 = (FIN2 + AF - 1) / AF;
  localparam int FW3 = (FIN3 + AF - 1) / AF;
  localparam int FW4 = (FIN4 + AF - 1) / AF;

  localparam logic [1:0] LAST_LAYER = 2'(LAYERS - 1);

  function automatic logic [CNT_WIDTH-1:0] fin_words_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return CNT_WIDTH'(FW1);
      2'd1:    return CNT_WIDTH'(FW2);
      2'd2:    return CNT_WIDTH'(FW3);
      default: return CNT_WIDTH'(FW4);
    endcase
  endfunction

  function automatic logic [CNT_WIDTH-1:0] fout_last_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return CNT_WIDTH'(FOUT1 - 1);
      2'd1:    return CNT_WIDTH'(FOUT2 - 1);
      2'd2:    return CNT_WIDTH'(FOUT3 - 1);
      default: return CNT_WIDTH'(FOUT4 - 1);
    endcase
  endfunction

  state_t               state;
  logic [CNT_WIDTH-1:0] fout_last;
  logic                 in_frame;
  logic                 proto_err;

  // Between LAYER_CFG and LAYER_END, the buffer must keep presenting the frame.
  assign in_frame  = state inside {LAYER_CFG, NEU_ISSUE, NEU_WAIT, LAYER_END};
  assign proto_err = (bus.neu_done && state != NEU_WAIT) ||
                     (!bus.FC_data_valid && in_frame);

  // NOTE: every register here, including the last-neuron compare value, is cleared by the
  // async reset. A reset mid-frame therefore leaves nothing behind that could skew the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      fout_last            <= '0;
      bus.FC_buffer_switch <= 1'b0;
      bus.layer_idx        <= '0;
      bus.fin_words        <= '0;
      bus.neu_idx          <= '0;
      bus.neu_start        <= 1'b0;
      bus.layer_done       <= 1'b0;
      bus.frame_cnt        <= '0;
      bus.busy             <= 1'b0;
      bus.err              <= 1'b0;
    end else begin
      bus.neu_start        <= 1'b0;
      bus.layer_done       <= 1'b0;
      bus.FC_buffer_switch <= 1'b0;
      if (proto_err) bus.err <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.enable) state <= WAIT_VALID;
        end

        WAIT_VALID: begin
          if (!bus.enable) begin
            state <= IDLE;
          end else if (bus.FC_data_valid) begin
            state         <= LAYER_CFG;
            bus.layer_idx <= '0;
            bus.busy      <= 1'b1;
          end
        end

        LAYER_CFG: begin
          bus.fin_words <= fin_words_of(bus.layer_idx);
          fout_last     <= fout_last_of(bus.layer_idx);
          bus.neu_idx   <= '0;
          bus.neu_start <= 1'b1;
          state         <= NEU_ISSUE;
        end

        NEU_ISSUE: begin
          state <= NEU_WAIT;
        end

        NEU_WAIT: begin
          if (bus.neu_done) begin
            if (bus.neu_idx == fout_last) begin
              bus.layer_done <= 1'b1;
              state          <= LAYER_END;
            end else begin
              bus.neu_idx   <= bus.neu_idx + CNT_WIDTH'(1);
              bus.neu_start <= 1'b1;
              state         <= NEU_ISSUE;
            end
          end
        end

        LAYER_END: begin
          if (bus.layer_idx == LAST_LAYER) begin
            bus.FC_buffer_switch <= 1'b1;
            bus.frame_cnt        <= bus.frame_cnt + CNT_WIDTH'(1);
            state                <= SWITCH;
          end else begin
            bus.layer_idx <= bus.layer_idx + 2'd1;
            state         <= LAYER_CFG;
          end
        end

        SWITCH: begin
          state <= DRAIN;
        end

        // The switch drops valid only after it sees the pulse, so valid must fall first.
        // Otherwise the same frame would be taken again.
        DRAIN: begin
          if (!bus.FC_data_valid) begin
            state    <= WAIT_VALID;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench for fc_layer_sequencer. It uses small layers (FOUT 4,3,2; FIN 7,5,5; AF 3) and a 4-bit counter,
// so the frame counter wraps within a short run.
module tb_fc_layer_sequencer;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fc_layer_sequencer_if #(.CNT_WIDTH(CW)) bus ();

  fc_layer_sequencer #(
    .LAYERS(3), .AF(3),
    .FIN1(7), .FIN2(5), .FIN3(5),
    .FOUT1(4), .FOUT2(3), .FOUT3(2),
    .CNT_WIDTH(CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // The engine model answers each neu_start with a neu_done three cycles later.
  // A separate injector creates out-of-protocol neu_done pulses.
  logic eng_done = 1'b0;
  logic inj_done = 1'b0;
  int   eng_dly  = 0;
  assign bus.neu_done = eng_done | inj_done;

  always @(negedge clk) begin
    if (rst) begin
      eng_dly  = 0;
      eng_done = 1'b0;
    end else begin
      eng_done = (eng_dly == 1);
      if (eng_dly > 0) eng_dly--;
      if (bus.neu_start) eng_dly = 3;
    end
  end

  // Pulse log: {layer_idx, neu_idx, fin_words} for each start, plus running pulse counts.
  logic [9:0] start_log[$];
  int   n_start = 0;
  int   n_ld    = 0;
  int   n_sw    = 0;
  int   n_wide  = 0;
  logic sw_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.neu_start) begin
      start_log.push_back({bus.layer_idx, bus.neu_idx, bus.fin_words});
      n_start++;
    end
    if (bus.layer_done) n_ld++;
    if (bus.FC_buffer_switch) begin
      n_sw++;
      if (sw_prev) n_wide++;
    end
    sw_prev = bus.FC_buffer_switch;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_switch"},     32'(bus.FC_buffer_switch), 0);
    check({tag, "_layer_idx"},  32'(bus.layer_idx),        0);
    check({tag, "_fin_words"},  32'(bus.fin_words),        0);
    check({tag, "_neu_idx"},    32'(bus.neu_idx),          0);
    check({tag, "_neu_start"},  32'(bus.neu_start),        0);
    check({tag, "_layer_done"}, 32'(bus.layer_done),       0);
    check({tag, "_frame_cnt"},  32'(bus.frame_cnt),        0);
    check({tag, "_busy"},       32'(bus.busy),             0);
    check({tag, "_err"},        32'(bus.err),              0);
  endtask

  task automatic wait_switch(input string tag, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.FC_buffer_switch) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_switch_seen"}, 32'(found), 1);
  endtask

  task automatic wait_start(input string tag, input int layer, input int idx, input int budget);
    bit found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.neu_start && int'(bus.layer_idx) == layer && int'(bus.neu_idx) == idx) begin
        found = 1'b1;
        break;
      end
    end
    check({tag, "_start_seen"}, 32'(found), 1);
  endtask

  task automatic run_frame(input string tag);
    bus.FC_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.FC_data_valid = 1'b1;
    wait_switch(tag, 200);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int         fout[3] = '{4, 3, 2};
    int         fin[3]  = '{3, 2, 2};
    int         k;
    int         s0;
    int         sw0;
    logic [9:0] exp_entry;

    bus.enable        = 1'b0;
    bus.FC_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    // Frame 1: full sequence and minimum start latency.
    @(negedge clk);
    bus.enable        = 1'b1;
    bus.FC_data_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("lat_cfg_no_start", 32'(bus.neu_start), 0);
    @(negedge clk);
    check("lat_first_start", 32'(bus.neu_start), 1);
    check("busy_in_frame", 32'(bus.busy), 1);
    wait_switch("f1", 200);
    check("f1_frame_cnt", 32'(bus.frame_cnt), 1);
    check("f1_err", 32'(bus.err), 0);
    check("f1_layer_done_cnt", n_ld, 3);
    check("f1_start_cnt", start_log.size(), 9);
    k = 0;
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < fout[l]; i++) begin
        exp_entry = {l[1:0], i[3:0], fin[l][3:0]};
        check($sformatf("f1_start%0d", k), 32'(start_log[k]), 32'(exp_entry));
        k++;
      end
    end

    // A stale valid held after the switch pulse keeps the sequencer in DRAIN.
    s0 = n_start;
    repeat (2) @(negedge clk);
    check("drain_busy", 32'(bus.busy), 1);
    check("drain_no_start", n_start, s0);
    bus.FC_data_valid = 1'b0;
    @(negedge clk);
    check("drain_exit_busy", 32'(bus.busy), 0);

    // Frame 2: enable drops during layer 2; the frame still completes.
    start_log.delete();
    sw0 = n_sw;
    bus.FC_data_valid = 1'b1;
    wait_start("f2", 1, 0, 200);
    bus.enable = 1'b0;
    wait_switch("f2", 200);
    check("f2_frame_cnt", 32'(bus.frame_cnt), 2);
    check("f2_start_cnt", start_log.size(), 9);
    bus.FC_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.FC_data_valid = 1'b1;
    repeat (20) @(negedge clk);
    check("f2_idle_busy", 32'(bus.busy), 0);
    check("f2_idle_no_start", start_log.size(), 9);
    check("f2_one_switch", n_sw - sw0, 1);

    // A stray neu_done in WAIT_VALID sets err, and the next frame still runs.
    bus.FC_data_valid = 1'b0;
    bus.enable        = 1'b1;
    @(negedge clk);
    check("inj_pre_busy", 32'(bus.busy), 0);
    check("inj_pre_err", 32'(bus.err), 0);
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    check("inj_err", 32'(bus.err), 1);
    check("inj_busy", 32'(bus.busy), 0);
    check("inj_no_start", 32'(bus.neu_start), 0);
    start_log.delete();
    bus.FC_data_valid = 1'b1;
    wait_switch("f3", 200);
    check("f3_start_cnt", start_log.size(), 9);
    check("f3_frame_cnt", 32'(bus.frame_cnt), 3);
    check("f3_err_sticky", 32'(bus.err), 1);

    // Reset while waiting on neuron 1 of layer 1.
    bus.FC_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    sw0 = n_sw;
    bus.FC_data_valid = 1'b1;
    wait_start("f4", 0, 1, 200);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    check("midrst_no_switch", n_sw, sw0);
    start_log.delete();
    rst = 1'b0;
    wait_switch("f5", 200);
    exp_entry = {2'd0, 4'd0, 4'd3};
    check("f5_first_start", 32'(start_log[0]), 32'(exp_entry));
    check("f5_start_cnt", start_log.size(), 9);
    check("f5_frame_cnt", 32'(bus.frame_cnt), 1);
    check("f5_err", 32'(bus.err), 0);

    // Frame counter wrap: 1 + 14 = 15, then one more frame wraps it to 0.
    for (int f = 0; f < 14; f++) run_frame("wrap");
    check("wrap_cnt15", 32'(bus.frame_cnt), 15);
    run_frame("wrap_last");
    check("wrap_cnt0", 32'(bus.frame_cnt), 0);
    check("wrap_err", 32'(bus.err), 0);

    // Valid falling mid-frame sets err, but the frame still runs to the switch.
    bus.FC_data_valid = 1'b0;
    repeat (3) @(negedge clk);
    bus.FC_data_valid = 1'b1;
    wait_start("drop", 1, 0, 200);
    bus.FC_data_valid = 1'b0;
    wait_switch("drop", 200);
    check("drop_err", 32'(bus.err), 1);
    check("drop_frame_cnt", 32'(bus.frame_cnt), 1);
    repeat (3) @(negedge clk);
    check("drop_busy", 32'(bus.busy), 0);

    // Totals: 20 switched frames of 9 neurons each, plus 2 starts in the reset-aborted frame.
    check("total_switch", n_sw, 20);
    check("total_layer_done", n_ld, 60);
    check("total_start", n_start, 182);
    check("switch_pulse_width", n_wide, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
